// File: rtl/instr_dispatch_pkg.sv
// Shared definitions for the instruction dispatcher: instruction field
// positions, opcode constants, error codes and FSM state encoding.
package instr_dispatch_pkg;

  // Instruction word layout: opcode[15:12], Ri[11:6], num/Rj[5:0]
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RI_MSB  = 11;
  localparam int RI_LSB  = 6;
  localparam int NUM_MSB = 5;
  localparam int NUM_LSB = 0;

  // Opcodes with an attached instruction FSM
  localparam logic [3:0] OP_ALUI = 4'd7;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ILLEGAL  = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_SPURIOUS = 2'd3
  } err_code_e;

  // Dispatcher state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RETIRE = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  // One-hot select of the FSM line belonging to an opcode
  function automatic logic [15:0] op_onehot(input logic [3:0] op);
    op_onehot = 16'd1 << op;
  endfunction

endpackage

// File: rtl/instr_dispatch_timer.sv
// WAIT-phase timer: loadable up-counter with synchronous clear and enable,
// flagging the last permitted WAIT cycle (count == TIMEOUT-1).
module dispatch_timer #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Counter register: clear has priority over load, load over count.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!reset)     count <= '0;
    else if (clear) count <= '0;
    else if (load)  count <= load_val;
    else if (en)    count <= count + 1'b1;
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/instr_dispatch.sv
// Initiator side of the per-instruction FSM start/done protocol. Accepts an
// instruction word, pulses the matching FSM start line, holds the decoded
// fields while that FSM runs, then retires or flags an error.
module instr_dispatch
  import instr_dispatch_pkg::*;
#(
  parameter logic [15:0] VALID_MASK = 16'h00FF,
  parameter int          TIMEOUT    = 64,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic [15:0]      fsm_start,
  input  logic [15:0]      fsm_done,
  output logic [3:0]       opCode,
  output logic [5:0]       Ri,
  output logic [5:0]       num,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code,
  input  logic             err_clr,
  output logic [CNT_W-1:0] retired
);

  localparam int TMR_W = $clog2(TIMEOUT);

  logic [2:0]  state, state_nx;
  err_code_e   err_q, err_nx;
  logic [15:0] start_hot;
  logic        done_ok, done_spur, timer_tc;

  assign start_hot = op_onehot(opCode);
  assign done_ok   = fsm_done[opCode];
  assign done_spur = |(fsm_done & ~start_hot);

  dispatch_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == ST_START),
    .en       (state == ST_WAIT),
    .load     (1'b0),
    .load_val ('0),
    .tc       (timer_tc)
  );

  // Next-state and next-error-code selection.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    state_nx = state;
    err_nx   = err_q;
    case (state)
      ST_IDLE:   if (instr_valid) state_nx = ST_DECODE;
      ST_DECODE: begin
        if (!VALID_MASK[opCode]) begin
          state_nx = ST_ERR;
          err_nx   = ERR_ILLEGAL;
        end else begin
          state_nx = ST_START;
        end
      end
      ST_START:  state_nx = ST_WAIT;
      ST_WAIT: begin
        // Correct done beats a stray done, which beats the timeout.
        if (done_ok) begin
          state_nx = ST_RETIRE;
        end else if (done_spur) begin
          state_nx = ST_ERR;
          err_nx   = ERR_SPURIOUS;
        end else if (timer_tc) begin
          state_nx = ST_ERR;
          err_nx   = ERR_TIMEOUT;
        end
      end
      ST_RETIRE: state_nx = ST_IDLE;
      ST_ERR: begin
        if (err_clr) begin
          state_nx = ST_IDLE;
          err_nx   = ERR_NONE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        err_nx   = ERR_NONE;
      end
    endcase
  end

  // State and sticky error-code registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      err_q <= ERR_NONE;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
    end
  end

  // Field latch: loaded only on accept, held until the next accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opCode <= '0;
      Ri     <= '0;
      num    <= '0;
    end else if (state == ST_IDLE && instr_valid) begin
      opCode <= instr[OPC_MSB:OPC_LSB];
      Ri     <= instr[RI_MSB:RI_LSB];
      num    <= instr[NUM_MSB:NUM_LSB];
    end
  end

  // Registered start strobe, high exactly while in START (glitch-free).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    fsm_start <= '0;
    else if (state_nx == ST_START) fsm_start <= start_hot;
    else                           fsm_start <= '0;
  end

  // Retired-instruction counter, wraps naturally at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  retired <= '0;
    else if (state == ST_RETIRE) retired <= retired + 1'b1;
  end

  assign instr_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign err         = (state == ST_ERR);
  assign err_code    = err_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// Self-checking bench for instr_dispatch: directed protocol cases plus a
// randomized instruction stream checked against an outcome model.
module tb_instr_dispatch;
  import instr_dispatch_pkg::*;

  localparam logic [15:0] MASK  = 16'h00FF;
  localparam int          TMO   = 8;
  localparam int          CW    = 4;
  localparam int          NEVER = 1000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          instr_valid = 1'b0;
  logic [15:0]   instr = '0;
  logic          instr_ready;
  logic [15:0]   fsm_start;
  logic [15:0]   fsm_done = '0;
  logic [3:0]    opCode;
  logic [5:0]    Ri;
  logic [5:0]    num;
  logic          busy;
  logic          err;
  logic [1:0]    err_code;
  logic          err_clr = 1'b0;
  logic [CW-1:0] retired;

  logic [15:0]   mask_v = MASK;
  int            n_checks = 0;
  int            n_errors = 0;
  int            exp_retired = 0;

  instr_dispatch #(
    .VALID_MASK (MASK),
    .TIMEOUT    (TMO),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .fsm_start   (fsm_start),
    .fsm_done    (fsm_done),
    .opCode      (opCode),
    .Ri          (Ri),
    .num         (num),
    .busy        (busy),
    .err         (err),
    .err_code    (err_code),
    .err_clr     (err_clr),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Outcome model: 0 = retire, otherwise the expected err_code. dd/sd are the
  // WAIT-cycle indices (0 = first cycle after START) of the correct done and
  // of a stray done. The last permitted WAIT index is TMO-1.
  function automatic int predict(input int op, input int dd, input int sd);
    if (!mask_v[op]) return 1;
    if (dd <= sd && dd <= TMO - 1) return 0;
    if (sd <= TMO - 1) return 3;
    return 2;
  endfunction

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  task automatic clear_err;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    check("clr_err",     32'(err), 32'd0);
    check("clr_code",    32'(err_code), 32'd0);
    check("clr_ready",   32'(instr_ready), 32'd1);
    check("clr_retired", 32'(retired), 32'(exp_retired));
  endtask

  // One instruction, starting and ending at a negedge in IDLE.
  task automatic run_instr(input logic [15:0] word, input int dd, input int sd, input int sbit);
    int op, oc, dec;
    op  = int'(word[15:12]);
    oc  = predict(op, dd, sd);
    dec = min3(dd, sd, TMO - 1);

    check("idle_ready", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr       = word;
    fsm_done    = 16'($urandom);
    tick;                                   // accept edge -> DECODE
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    fsm_done    = 16'($urandom);
    check("acc_fields", 32'({opCode, Ri, num}), 32'(word));
    check("acc_busy",   32'({busy, instr_ready}), 32'b10);
    check("dec_start",  32'(fsm_start), 32'd0);
    tick;                                   // START or ERR
    if (oc == 1) begin
      fsm_done = '0;
      check("ill_err",   32'({err, err_code}), 32'b101);
      check("ill_start", 32'(fsm_start), 32'd0);
      tick;
      check("ill_hold",  32'({err, err_code, fsm_start}), {13'd0, 3'b101, 16'd0});
      clear_err;
      return;
    end
    check("start_hot", 32'(fsm_start), 32'd1 << op);
    fsm_done = 16'($urandom);
    tick;                                   // WAIT index 0
    for (int k = 0; k <= dec; k++) begin
      check("wait_start",  32'(fsm_start), 32'd0);
      check("wait_fields", 32'({opCode, Ri, num}), 32'(word));
      fsm_done = '0;
      if (k == dd) fsm_done[op]   = 1'b1;
      if (k == sd) fsm_done[sbit] = 1'b1;
      tick;
      fsm_done = '0;
      if (k != dec) check("wait_state", 32'({busy, err}), 32'b10);
    end
    if (oc == 0) begin
      check("ret_state", 32'({busy, err}), 32'b10);
      check("ret_pre",   32'(retired), 32'(exp_retired));
      fsm_done = 16'($urandom);
      tick;
      fsm_done = '0;
      exp_retired = (exp_retired + 1) % (1 << CW);
      check("ret_count",  32'(retired), 32'(exp_retired));
      check("ret_ready",  32'(instr_ready), 32'd1);
      check("ret_fields", 32'({opCode, Ri, num}), 32'(word));
    end else begin
      check("err_flag",    32'({err, instr_ready}), 32'b10);
      check("err_code",    32'(err_code), 32'(oc));
      check("err_retired", 32'(retired), 32'(exp_retired));
      fsm_done = 16'($urandom);
      tick;
      fsm_done = '0;
      check("err_hold",  32'({err, err_code}), 32'(4 + oc));
      check("err_start", 32'(fsm_start), 32'd0);
      clear_err;
    end
  endtask

  // Three words with instr_valid held high; done 5 cycles after each start.
  // Accept-to-accept period is 9 edges: 0 DECODE, 1 START, 2..6 WAIT,
  // 7 RETIRE, 8 IDLE.
  task automatic run_back_to_back;
    logic [15:0] w [3];
    int base, phase, idx;
    logic [15:0] exp_start;
    base = exp_retired;
    for (int i = 0; i < 3; i++) w[i] = {1'b0, 3'($urandom), 12'($urandom)};
    instr_valid = 1'b1;
    instr       = w[0];
    fsm_done    = '0;
    for (int c = 0; c < 27; c++) begin
      tick;
      phase = c % 9;
      idx   = c / 9;
      exp_start = (phase == 1) ? op_onehot(w[idx][15:12]) : 16'd0;
      check("b2b_fields",  32'({opCode, Ri, num}), 32'(w[idx]));
      check("b2b_start",   32'(fsm_start), 32'(exp_start));
      check("b2b_ready",   32'(instr_ready), 32'(phase == 8));
      check("b2b_retired", 32'(retired), 32'((base + (c + 1) / 9) % (1 << CW)));
      if (phase == 0) begin
        if (idx < 2) instr = w[idx + 1];
        else         instr_valid = 1'b0;
      end
      fsm_done = (phase == 6) ? op_onehot(w[idx][15:12]) : 16'd0;
    end
    fsm_done    = '0;
    exp_retired = (base + 3) % (1 << CW);
  endtask

  initial begin
    int op, dd, sd, sbit;

    repeat (2) tick;
    check("rst_ready",  32'({instr_ready, busy, err, err_code}), 32'b10000);
    check("rst_outs",   32'({fsm_start, opCode, Ri, num}), 32'd0);
    check("rst_retire", 32'(retired), 32'd0);
    reset = 1'b1;
    tick;

    // Reset asserted in WAIT drops the instruction immediately.
    instr_valid = 1'b1;
    instr       = 16'h1234;
    tick;
    instr_valid = 1'b0;
    repeat (3) tick;
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_state", 32'({instr_ready, busy, err}), 32'b100);
    check("mid_rst_outs",  32'({fsm_start, opCode, Ri, num}), 32'd0);
    check("mid_rst_ret",   32'(retired), 32'(exp_retired));
    tick;
    reset = 1'b1;
    tick;

    // Directed cases
    run_instr(16'h7083, 4, NEVER, 0);        // ALUI, done 5 cycles after start
    run_instr(16'hA000, NEVER, NEVER, 0);    // illegal opcode
    run_instr(16'h3155, NEVER, NEVER, 0);    // timeout
    run_instr(16'h2041, NEVER, 1, 5);        // stray done[5]
    run_instr(16'h2041, 2, 2, 5);            // correct and stray together
    run_instr(16'h5abc, TMO - 1, NEVER, 0);  // done on the timeout cycle
    run_instr(16'h4000, NEVER, TMO - 1, 9);  // stray on the timeout cycle
    run_instr(16'h0fff, 0, NEVER, 0);        // done in first WAIT cycle

    run_back_to_back;

    // Random stream
    for (int t = 0; t < 60; t++) begin
      op   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
      dd   = int'($urandom_range(0, 11));
      sd   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 9)) : NEVER;
      sbit = (op + 1 + int'($urandom_range(0, 14))) % 16;
      run_instr({4'(op), 12'($urandom)}, dd, sd, sbit);
    end

    // Drive the counter to all-ones, then one more completion wraps it.
    for (int g = 0; g < 16 && exp_retired != (1 << CW) - 1; g++)
      run_instr({OP_ALUI, 12'($urandom)}, 1, NEVER, 0);
    check("wrap_pre", 32'(retired), 32'((1 << CW) - 1));
    run_instr({OP_ALUI, 12'h083}, 4, NEVER, 0);
    check("wrap_zero", 32'(retired), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_dispatch.md
Name: instr_dispatch

Overview:
- Initiator side of the per-instruction FSM start/done protocol.
- Accepts 16-bit instruction words from fetch over a valid/ready handshake and decodes fields as opcode[15:12], Ri[11:6], num/Rj[5:0].
- Pulses the one matching FSM start line, holds the decoded fields stable while that FSM runs, then waits for its done.
- Retires the instruction, or flags illegal-opcode, timeout and spurious-done errors.

Parameters:
- VALID_MASK, 16'h00FF: bit k=1 means opcode k has an attached FSM; a cleared bit makes opcode k illegal.
- TIMEOUT, 64: WAIT cycles allowed before a timeout error; must be >= 2.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; all state is cleared while reset=0.
- instr_valid  in  1  fetch has a word on instr.
- instr  in  16  instruction word.
- instr_ready  out  1  dispatcher can accept a word.
- fsm_start  out  16  one-hot start strobes, index = opcode.
- fsm_done  in  16  done lines from the instruction FSMs, index = opcode.
- opCode  out  4  latched opcode, held until the next accept.
- Ri  out  6  latched Ri field.
- num  out  6  latched num/Rj field.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky error flag.
- err_code  out  2  0 none, 1 illegal opcode, 2 timeout, 3 spurious done.
- err_clr  in  1  clears the error state, sampled in ERR only.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset values: state=IDLE; fsm_start, opCode, Ri, num, err, err_code, retired, busy all 0; instr_ready=1.
- States: IDLE, DECODE, START, WAIT, RETIRE, ERR. State register is async-reset; next-state logic is combinational; outputs are registered or decoded from state, glitch-free on fsm_start.
- IDLE:
  - instr_ready=1.
  - If instr_valid=1 at a rising edge: latch instr into opCode/Ri/num and go to DECODE.
  - If instr_valid=0: stay. Nothing is latched.
- DECODE (1 cycle), instr_ready=0:
  - VALID_MASK[opCode]=0 -> ERR with err_code=1.
  - Otherwise -> START.
- START (exactly 1 cycle):
  - fsm_start[opCode]=1, all other bits 0.
  - Clear the timer, go to WAIT.
- WAIT: fsm_start=0; timer increments each cycle.
  - fsm_done[opCode]=1 -> RETIRE. This wins over a simultaneous timeout.
  - Any other fsm_done bit high -> ERR with err_code=3. If the correct done bit is also high that cycle, it wins.
  - timer==TIMEOUT-1 with no done -> ERR with err_code=2.
- RETIRE (1 cycle): retired <= retired+1, wrapping all-ones to 0; then go to IDLE.
- ERR:
  - err=1; err_code is held; instr_ready=0; no start strobes are issued.
  - err_clr=1 -> IDLE and err/err_code are cleared. retired is not changed.
- Field hold: opCode, Ri and num must not change from the accept edge until the next accept. The FSMs sample them at arbitrary points during execution.
- Throughput: minimum accept-to-accept is 4 cycles plus FSM latency.
  - Accept at edge N gives fsm_start high in cycle N+2.
  - A 5-state FSM (INIT->...->NEXT_I) asserts done 5 cycles after start; the next accept is then possible 2 cycles later.
- fsm_done bits seen in IDLE, DECODE, START, RETIRE or ERR are ignored. Only WAIT checks for spurious done.
- Reset asserted mid-operation: outputs return to their reset values immediately (asynchronously). The in-flight instruction is dropped with no retire count.

Decomposition:
- Shared package contains:
  - Opcode constants, e.g. OP_ALUI=4'd7.
  - Field bit positions OPC_MSB=15, RI_LSB=6.
  - err_code enumeration ERR_NONE/ERR_ILLEGAL/ERR_TIMEOUT/ERR_SPURIOUS.
  - State encoding localparams.
- One sub-module, dispatch_timer: a loadable up-counter with clear, enable, and a terminal-count output compared against TIMEOUT-1.

Test Plan:
- ALUI instruction (instr=16'h7083, opcode 7, Ri=2, num=3) with a model FSM giving done 5 cycles after start -> fsm_start=16'h0080 for exactly one cycle; opCode=7, Ri=2, num=3 held throughout; retired 0->1; instr_ready returns to 1.
- Illegal opcode with VALID_MASK=16'h00FF, instr=16'hA000 -> no fsm_start bit ever asserts; err=1, err_code=1; after an err_clr pulse, IDLE with err=0.
- TIMEOUT=8, opcode 3, model FSM never asserts done -> err_code=2 exactly 8 cycles after the START cycle; retired unchanged.
- Opcode 2 started, fsm_done[5] pulses in WAIT -> err_code=3. A second run pulses fsm_done[2] and fsm_done[5] together -> RETIRE, no error.
- Back-to-back: instr_valid held high with 3 queued words -> each is accepted only in IDLE; retired=3; fields update only at the accept edges.
- reset driven low in WAIT -> fsm_start=0, busy=0, retired unchanged, instr_ready=1 immediately; retired wraps 16'hFFFF->0 on the next completion.
